// File: rtl/qk_sched.sv
// qk_sched: round-robin scheduler that shares one QK-score engine between
// NUM_REQ requesters. A granted requester owns the engine for a full
// start/run/release job; the rotating pointer moves past the last winner so
// every active requester is served in turn.
//
// Build option: define QK_SCHED_WATCHDOG_EN to include a WAIT-state watchdog
// that forces a release after TIMEOUT cycles and records a sticky error.
// Without it the scheduler waits for eng_done indefinitely and the error
// outputs are tied low.
module qk_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 600000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       eng_start,
  input  logic                       eng_done,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] err_id
);

  localparam int SW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [SW-1:0]      ptr_reg, ptr_next;
  logic [SW-1:0]      sel_reg, sel_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;

  logic [SW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               any_req;
  logic               wd_expire;
  int                 cand;

  // Out-of-range parameters elaborate an obviously named scope that shows up
  // in the hierarchy; legal ranges leave no trace.
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 20'hFFFFF) begin : g_param_out_of_range
  end

  assign any_req = |req;

  // Round-robin search: the smallest offset from ptr wins, so offsets are
  // scanned high-to-low and each later hit overrides the earlier one.
  always_comb begin
    win_idx = ptr_reg;
    cand    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr_reg) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        win_idx = SW'(cand);
      end
    end
  end

  // One-hot image of the winning index, loaded into gnt on arbitration.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == SW'(gi));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: eng_done only matters while waiting on the engine.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done || wd_expire) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping: capture the winner in IDLE, hold it through the job,
  // then drop gnt and move the pointer just past the finished requester.
  always_comb begin
    ptr_next = ptr_reg;
    sel_next = sel_reg;
    gnt_next = gnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          sel_next = win_idx;
          gnt_next = win_onehot;
        end
      end
      ST_RELEASE: begin
        gnt_next = '0;
        if (sel_reg == SW'(NUM_REQ - 1)) begin
          ptr_next = '0;
        end else begin
          ptr_next = sel_reg + SW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Grant, select and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
      sel_reg <= '0;
      gnt_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      sel_reg <= sel_next;
      gnt_reg <= gnt_next;
    end
  end

  // Outputs decoded from state; req_done reuses the held one-hot grant.
  always_comb begin
    eng_start = (state_reg == ST_START);
    busy      = (state_reg != ST_IDLE);
    req_done  = '0;
    if (state_reg == ST_RELEASE) begin
      req_done = gnt_reg;
    end
  end

  assign gnt = gnt_reg;
  assign sel = sel_reg;

`ifdef QK_SCHED_WATCHDOG_EN
  localparam logic [19:0] TIMEOUT_W = 20'(TIMEOUT);

  logic [19:0]   wd_cnt_reg;
  logic [19:0]   wd_cnt_inc;
  logic          timeout_err_reg;
  logic [SW-1:0] err_id_reg;

  // Expiry fires in the WAIT cycle whose increment reaches TIMEOUT; a
  // simultaneous eng_done wins and counts as a normal completion.
  assign wd_cnt_inc = wd_cnt_reg + 20'd1;
  assign wd_expire  = (state_reg == ST_WAIT) && !eng_done && (wd_cnt_inc == TIMEOUT_W);

  // Watchdog counter: cleared while heading into WAIT, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_START) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      wd_cnt_reg <= wd_cnt_inc;
    end
  end

  // Sticky error flag; each new timeout overwrites the recorded requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_reg <= 1'b0;
      err_id_reg      <= '0;
    end else if (wd_expire) begin
      timeout_err_reg <= 1'b1;
      err_id_reg      <= sel_reg;
    end
  end

  assign timeout_err = timeout_err_reg;
  assign err_id      = err_id_reg;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
  assign err_id      = '0;
`endif

endmodule

// File: doc/qk_sched.md
QK_SCHED -- requirements
Module: qk_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one QK-score engine (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 600000, meaning watchdog limit in clk cycles (1..2^20-1).
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  level request per requester, held until its req_done.
REQ-006 SHALL have port gnt  output  NUM_REQ  one-hot grant, held for the whole job.
REQ-007 SHALL have port sel  output  $clog2(NUM_REQ)  index of granted requester (Q/K operand mux select).
REQ-008 SHALL have port eng_start  output  1  one-cycle start pulse to the engine.
REQ-009 SHALL have port eng_done  input  1  engine completion pulse.
REQ-010 SHALL have port req_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port timeout_err  output  1  sticky watchdog error flag.
REQ-013 SHALL have port err_id  output  $clog2(NUM_REQ)  index of requester whose job timed out last.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT, RELEASE.
REQ-015 IDLE: if any req bit set, SHALL register winner into sel and gnt and go START; else stay.
REQ-016 Winner SHALL be first set req index scanning ascending from rotating pointer ptr, wrapping NUM_REQ-1 -> 0.
REQ-017 START: eng_start SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-018 WAIT: on eng_done=1 SHALL go RELEASE; eng_done outside WAIT SHALL be ignored.
REQ-019 RELEASE: req_done[sel] SHALL be 1 this cycle only; gnt SHALL clear at end of cycle; ptr SHALL become (sel+1) mod NUM_REQ; next state IDLE.
REQ-020 Latency: req sampled at edge N -> gnt high after N, eng_start high cycle after N+1, req_done pulse cycle after eng_done sampled.
REQ-021 Deassertion of a granted req mid-job SHALL NOT abort; job completes and req_done still pulses.
REQ-022 Requester holding req in the cycle after its req_done SHALL be re-arbitrated at lowest priority (ptr already advanced).
REQ-023 gnt, sel SHALL be stable from START through RELEASE; sel SHALL hold last value in IDLE.
REQ-024 Back-to-back jobs: minimum 4 cycles between successive eng_start pulses plus engine run time.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, ptr 0, gnt 0, sel 0, eng_start 0, req_done 0, busy 0, timeout_err 0, err_id 0, watchdog counter 0.
REQ-026 Reset mid-job SHALL abort without any req_done pulse; engine is reset by the same rst.
REQ-027 First edge after rst release SHALL perform normal IDLE arbitration.

Configuration
REQ-028 Macro QK_SCHED_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-029 With macro: 20-bit counter clears on entering WAIT, increments each WAIT cycle; on reaching TIMEOUT without eng_done SHALL go RELEASE, set timeout_err=1, err_id=sel, and still pulse req_done[sel].
REQ-030 With macro: eng_done in the same cycle counter reaches TIMEOUT SHALL count as normal completion, no error.
REQ-031 With macro: timeout_err SHALL clear only on reset; further timeouts overwrite err_id.
REQ-032 Without macro: no counter, WAIT persists until eng_done, timeout_err and err_id tied 0.

Verification
REQ-033 Single requester: req=4'b0001, eng_done 10 cycles after eng_start -> gnt=0001, sel=0, one eng_start, req_done=0001 one cycle, ptr=1.
REQ-034 Fairness: req=4'b1111 held, ptr=0 -> grant order 0,1,2,3,0 with exactly one eng_start per job.
REQ-035 Wrap: ptr=3, req=4'b0101 -> sel=0 then sel=2.
REQ-036 Abort: rst=0 during WAIT -> all outputs 0 asynchronously, no req_done; req=0010 after release -> sel=1.
REQ-037 Watchdog (macro on, TIMEOUT=50): eng_done never pulses, sel=2 -> RELEASE after 50 WAIT cycles, req_done=0100, timeout_err=1, err_id=2; later normal job leaves timeout_err=1.
REQ-038 Spurious eng_done in IDLE and START -> no state change, no req_done.
